// File: rtl/aes_round_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : aes_round_ctrl_if
// Brief  : Handshake, key-expansion and datapath-strobe bundle of aes_round_ctrl.
//          AES_ROUND_CTRL_BLK_CNT_EN adds the blk_cnt signal.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface aes_round_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cfg_key_valid;
    logic [1:0]       cfg_key_type;
    logic             cfg_key_ready;
    logic             key_err;
    logic             kx_key_in_valid;
    logic [1:0]       kx_key_in_type;
    logic             kx_key_loaded;
    logic             blk_in_valid;
    logic             blk_in_ready;
    logic             blk_out_valid;
    logic             blk_out_ready;
    logic [3:0]       rk_addr;
    logic             dp_load;
    logic             dp_round_en;
    logic             dp_final;
    logic             key_valid;
`ifdef AES_ROUND_CTRL_BLK_CNT_EN
    logic [CNT_W-1:0] blk_cnt;
`endif

    // Controller side
    modport slave (
        input  cfg_key_valid, cfg_key_type, kx_key_loaded, blk_in_valid, blk_out_ready,
        output cfg_key_ready, key_err, kx_key_in_valid, kx_key_in_type, blk_in_ready,
        output blk_out_valid, rk_addr, dp_load, dp_round_en, dp_final, key_valid
`ifdef AES_ROUND_CTRL_BLK_CNT_EN
        , output blk_cnt
`endif
    );

    // Requester / datapath side
    modport master (
        output cfg_key_valid, cfg_key_type, kx_key_loaded, blk_in_valid, blk_out_ready,
        input  cfg_key_ready, key_err, kx_key_in_valid, kx_key_in_type, blk_in_ready,
        input  blk_out_valid, rk_addr, dp_load, dp_round_en, dp_final, key_valid
`ifdef AES_ROUND_CTRL_BLK_CNT_EN
        , input blk_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
//------------------------------------------------------------------------------
// Module : aes_round_ctrl
// Brief  : Sequences key_expansion loading and the AES round datapath, one
//          round per cycle. AES_ROUND_CTRL_BLK_CNT_EN enables the block counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_round_ctrl #(
    parameter int LOAD_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    aes_round_ctrl_if.slave bus
);

    localparam int               c_TO_W    = $clog2(LOAD_TIMEOUT) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_NOKEY    = 3'd0,
        ST_KEY_LOAD = 3'd1,
        ST_READY    = 3'd2,
        ST_ROUND    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_type;
    logic [3:0]        r_round;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_key_valid;
    logic [3:0]        w_nr;
    logic              w_load_start;
    logic              w_accept;
    logic              w_out_hs;

    always_comb begin
        case (r_type)
            2'b01:   w_nr = 4'd12;
            2'b10:   w_nr = 4'd14;
            default: w_nr = 4'd10;
        endcase
    end

    always_comb begin
        w_next_state        = r_state;
        w_load_start        = 1'b0;
        w_accept            = 1'b0;
        w_out_hs            = 1'b0;
        bus.cfg_key_ready   = 1'b0;
        bus.key_err         = 1'b0;
        bus.kx_key_in_valid = 1'b0;
        bus.blk_in_ready    = 1'b0;
        bus.blk_out_valid   = 1'b0;
        bus.rk_addr         = 4'd0;
        bus.dp_load         = 1'b0;
        bus.dp_round_en     = 1'b0;
        bus.dp_final        = 1'b0;
        case (r_state)
            ST_NOKEY: begin
                bus.cfg_key_ready = 1'b1;
                if (bus.cfg_key_valid) begin
                    if (bus.cfg_key_type == 2'b11) begin
                        bus.key_err = 1'b1;
                    end else begin
                        w_load_start = 1'b1;
                        w_next_state = ST_KEY_LOAD;
                    end
                end
            end
            ST_KEY_LOAD: begin
                bus.kx_key_in_valid = 1'b1;
                if (bus.kx_key_loaded) begin
                    w_next_state = ST_READY;
                end else if (r_to_cnt == c_TO_LAST) begin
                    bus.key_err  = 1'b1;
                    w_next_state = ST_NOKEY;
                end
            end
            ST_READY: begin
                bus.cfg_key_ready = 1'b1;
                bus.blk_in_ready  = ~bus.cfg_key_valid;
                // A key request wins over a block offered in the same cycle
                if (bus.cfg_key_valid) begin
                    if (bus.cfg_key_type == 2'b11) begin
                        bus.key_err = 1'b1;
                    end else begin
                        w_load_start = 1'b1;
                        w_next_state = ST_KEY_LOAD;
                    end
                end else if (bus.blk_in_valid) begin
                    w_accept     = 1'b1;
                    bus.dp_load  = 1'b1;
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                bus.dp_round_en = 1'b1;
                bus.rk_addr     = r_round;
                if (r_round == w_nr) begin
                    bus.dp_final = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.blk_out_valid = 1'b1;
                if (bus.blk_out_ready) begin
                    w_out_hs     = 1'b1;
                    w_next_state = ST_READY;
                end
            end
            default: w_next_state = ST_NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_NOKEY;
            r_type      <= 2'b00;
            r_round     <= 4'd0;
            r_to_cnt    <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load_start) begin
                r_type <= bus.cfg_key_type;
            end
            if (w_accept) begin
                r_round <= 4'd1;
            end else if (r_state == ST_ROUND) begin
                r_round <= r_round + 4'd1;
            end
            if ((r_state == ST_KEY_LOAD) && (w_next_state == ST_KEY_LOAD)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_load_start) begin
                r_key_valid <= 1'b0;
            end else if ((r_state == ST_KEY_LOAD) && bus.kx_key_loaded) begin
                r_key_valid <= 1'b1;
            end
        end
    end

    assign bus.kx_key_in_type = r_type;
    assign bus.key_valid      = r_key_valid;

`ifdef AES_ROUND_CTRL_BLK_CNT_EN
    logic [CNT_W-1:0] r_blk_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk_cnt <= '0;
        end else if (w_load_start) begin
            r_blk_cnt <= '0;
        end else if (w_out_hs) begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

    assign bus.blk_cnt = r_blk_cnt;
`endif

endmodule

`default_nettype wire
